countdown_ctrl: RTL and testbench

Sequencing controller for the slow-tick prescaler path: owns a divide-by-DIV prescaler, gates it on and off, and counts its ticks down from a loaded value. Drives a start/pause/clear countdown (lab timer/stopwatch style) and pulses `done` on expiry. Sits between the debounced front-panel controls and the display/LED logic.

---
 rtl/countdown_ctrl.sv | 155 +++++++++++++++
 tb/tb_countdown_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Start/pause/clear countdown controller driven by a divide-by-DIV
//   prescaler. The prescaler only advances while the countdown is running
//   and pause is low. Each prescaler wrap is one tick, and each tick
//   decrements count. When count expires, done pulses for one cycle.
//
//   Parameters:
//     DIV  in_clk cycles per tick (>= 2)
//     CW   countdown width
//
//   Ports:
//     in_clk    system clock (rising edge)
//     rst_n     asynchronous active-low reset
//     start     one-cycle request: load load_val and run
//     pause     level: hold the countdown while high
//     clear     one-cycle request: abort to IDLE
//     load_val  countdown start value, sampled on an accepted start
//     count     remaining ticks
//     tick_out  one-cycle pulse for each tick taken
//     done      one-cycle pulse on expiry
//     state     IDLE=00 RUN=01 PAUSE=10 DONE=11
//     busy      high in RUN or PAUSE
//
//   Build option:
//     COUNTDOWN_AUTORELOAD_EN  On expiry, reload from the live load_val
//                              and keep running. If load_val is 0, go to
//                              DONE instead.

module countdown_ctrl #(
    parameter int DIV = 40000000,
    parameter int CW  = 8
) (
    input  logic          in_clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    input  logic          clear,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] count,
    output logic          tick_out,
    output logic          done,
    output logic [1:0]    state,
    output logic          busy
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic          advance;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            busy_q  <= (state_d == RUN) || (state_d == PAUSE);
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        advance = 1'b0;

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            presc_d = '0;
        end else if (start) begin
            presc_d = '0;
            if (load_val != '0) begin
                state_d = RUN;
                count_d = load_val;
            end else begin
                state_d = DONE;
                count_d = '0;
                done_d  = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) state_d = PAUSE;
                    else       advance = 1'b1;
                end
                // The cycle that leaves PAUSE already advances the prescaler.
                // This way each paused cycle costs exactly one cycle of delay.
                PAUSE: begin
                    if (!pause) begin
                        state_d = RUN;
                        advance = 1'b1;
                    end
                end
                default: count_d = '0;    // IDLE and DONE hold count at zero
            endcase
        end

        if (advance) begin
            if (presc_q == PW'(DIV - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
                // A count of 0 cannot occur in RUN. It is treated as expiry
                // anyway, so count never wraps below zero.
                if (count_q <= CW'(1)) begin
                    done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    if (load_val != '0) begin
                        count_d = load_val;
                    end else begin
                        count_d = '0;
                        state_d = DONE;
                    end
`else
                    count_d = '0;
                    state_d = DONE;
`endif
                end else begin
                    count_d = count_q - 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign count    = count_q;
    assign tick_out = tick_q;
    assign done     = done_q;
    assign state    = state_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

    localparam int DIV = 4;
    localparam int CW  = 4;

    logic          in_clk = 1'b0;
    logic          rst_n;
    logic          start, pause, clear;
    logic [CW-1:0] load_val;
    logic [CW-1:0] count;
    logic          tick_out, done, busy;
    logic [1:0]    state;

    countdown_ctrl #(.DIV(DIV), .CW(CW)) dut (
        .in_clk(in_clk), .rst_n(rst_n), .start(start), .pause(pause),
        .clear(clear), .load_val(load_val), .count(count),
        .tick_out(tick_out), .done(done), .state(state), .busy(busy)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        int        ed;
        int        st;
        int        cnt;
        logic      tk;
        logic      dn;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;

    // Reference model. It tracks the run progress (cycles spent running),
    // the remaining ticks, and a mode in the spec's encoding.
    int mode = 0, rem = 0, adv = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: pops the expectation for the edge just taken.
    always @(negedge in_clk) begin
        if (mon_en && rst_n) begin
            if (q.size() > 0 && q[0].ed <= cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("state", int'(state), e.st);
                chk("count", int'(count), e.cnt);
                chk("tick_out", int'(tick_out), int'(e.tk));
                chk("done", int'(done), int'(e.dn));
                chk("busy", int'(busy), int'(e.st == 1 || e.st == 2));
            end else begin
                chk("unexpected_pulse", int'(tick_out | done), 0);
            end
        end
    end

    // Called at a negedge. Drives one cycle of inputs, then pushes the
    // expected result after the next rising edge.
    task automatic step(input logic st, input logic cl, input logic p, input logic [CW-1:0] lv);
        exp_t e;
        logic tk, dn;
        start = st; clear = cl; pause = p; load_val = lv;
        tk = 1'b0; dn = 1'b0;
        if (cl) begin
            mode = 0; rem = 0; adv = 0;
        end else if (st) begin
            adv = 0;
            if (lv != 0) begin mode = 1; rem = int'(lv); end
            else begin mode = 3; rem = 0; dn = 1'b1; end
        end else if (mode == 1 || mode == 2) begin
            if (p) mode = 2;
            else begin
                mode = 1;
                adv++;
                if (adv % DIV == 0) begin
                    tk = 1'b1;
                    rem--;
                    if (rem == 0) begin
                        dn = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        if (lv != 0) rem = int'(lv);
                        else mode = 3;
`else
                        mode = 3;
`endif
                    end
                end
            end
        end
        e.ed = cyc + 1; e.st = mode; e.cnt = rem; e.tk = tk; e.dn = dn;
        q.push_back(e);
        @(negedge in_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; pause = 0; clear = 0; load_val = '0;
        repeat (3) @(negedge in_clk);
        chk("rst_count", int'(count), 0);
        chk("rst_tick", int'(tick_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge in_clk);
        mon_en = 1'b1;

        // Start with 3 at edge k. Ticks follow at k+4, k+8, k+12.
        step(1'b1, 1'b0, 1'b0, 4'd3);
        idle(15);

        // Same run, with pause sampled high at edges k+6..k+10.
        step(1'b1, 1'b0, 1'b0, 4'd3);
        for (int i = 1; i <= 20; i++) step(1'b0, 1'b0, (i >= 6 && i <= 10), 4'd0);

        // Clear and start together at k+5. Clear wins.
        step(1'b1, 1'b0, 1'b0, 4'd5);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 4'd7);
        idle(30);

        // Start with a load value of 0.
        step(1'b1, 1'b0, 1'b0, 4'd0);
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 7)));
        end

        // Drain the scoreboard.
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(2);
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge in_clk);
        chk("drain_left", q.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset while a count is running.
        start = 1'b1; load_val = 4'd5; clear = 1'b0; pause = 1'b0;
        @(negedge in_clk);
        start = 1'b0;
        repeat (6) @(negedge in_clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_tick", int'(tick_out), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_busy", int'(busy), 0);
        repeat (3) @(negedge in_clk);
        chk("arst_hold_done", int'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
